rr_therm_arbiter: RTL and testbench
===================================

Name: rr_therm_arbiter

Overview:
- Round-robin arbiter sharing one SC datapath resource (e.g. one canonical-form converter or bitstream generator) between N requesters.
- Priority masking uses a one-hot-to-thermometer conversion of the last-granted one-hot vector.
- Grants are registered, one-hot, and held until the owner releases.
- An optional hold-timeout forcibly revokes a stuck owner.

Parameters:
- N, 8, number of requesters; power of 2, N >= 2
- MAX_HOLD, 256, maximum grant-hold cycles before forced revoke; used only with ARB_TIMEOUT_EN; >= 2
- IW, $clog2(N), width of the grant index; derived, not to be overridden

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-requester request level
- done  input  1  current owner finished; qualified by busy
- gnt  output  N  registered one-hot grant; all zero when idle
- gnt_idx  output  IW  binary index of the set gnt bit; holds last value when idle
- busy  output  1  1 when gnt is nonzero
- timeout  output  1  one-cycle pulse on forced revoke

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, gnt_idx=0, busy=0, timeout=0, state IDLE.
  - Internal last-grant register last_oh = one-hot bit N-1, so the first arbitration starts at bit 0.
  - Hold counter = 0.
- Mask generation:
  - therm = onehot_to_therm(last_oh, DIR=1); e.g. 00001000 -> 11111000.
  - above = therm & ~last_oh, i.e. requesters strictly above the last grant.
- Winner selection (combinational):
  - If (req & above) != 0, the winner is its lowest set bit.
  - Otherwise the winner is the lowest set bit of req.
  - The winner is always one-hot or zero.
- FSM states: IDLE, BUSY.
  - IDLE: if |req, the next cycle gives gnt=winner, gnt_idx=index(winner), last_oh=winner, busy=1, state BUSY. Latency is req to gnt in 1 cycle. If req=0, stay IDLE.
  - BUSY: release = done | ~req[gnt_idx] | forced (the last only with ARB_TIMEOUT_EN). A dropped request is treated as an implicit done.
  - BUSY with release and winner != 0: the next cycle moves gnt directly to the new winner, with no idle gap, and stays BUSY. The releasing requester may win again only if no other requester is pending, because of the mask.
  - BUSY with release and winner == 0: the next cycle gives gnt=0, busy=0, state IDLE. gnt_idx and last_oh are retained.
  - BUSY without release: gnt is held unchanged regardless of other req changes.
- Boundary and simultaneous-event rules:
  - done while IDLE is ignored.
  - A new req arriving in the same cycle as a release participates in that cycle's arbitration.
  - Wrap-around: last_oh = bit N-1 gives above = 0, so selection falls back to the lowest set bit.
  - rst_n asserted mid-grant clears everything immediately; no grant survives reset.
- Invariants:
  - gnt is never multi-hot.
  - busy == |gnt.
  - gnt changes only on a clock edge or on reset.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro:
  - A hold counter clears on every new grant and increments each BUSY cycle without release.
  - When the counter reaches MAX_HOLD-1, forced=1. The grant is released that cycle as a normal release, so a pending other requester gets gnt next cycle.
  - timeout pulses 1 for exactly one cycle, registered alongside the gnt change.
- Without the macro:
  - There is no counter and forced=0.
  - timeout is tied to 0.
  - The port list is unchanged.

Decomposition:
- Shared package sc_arb_pkg:
  - typedef arb_state_e {IDLE, BUSY}.
  - Function lowest_onehot(vector), and function onehot_to_idx(vector).
- Sub-module: the existing onehot_to_therm, instantiated once with N and DIR=1 for mask generation.
- Everything else stays inline.

Test Plan (N=8, MAX_HOLD=4 for the timeout case):
- Reset, then req=8'b0000_0001 -> gnt=0000_0001 and gnt_idx=0 one cycle later; pulse done -> gnt=0 and busy=0 next cycle.
- req=8'b1000_1001 held, done pulsed after each grant -> grant order is bit 0, 3, 7, 0 with no idle cycles between grants.
- Owner bit 3 with req=0000_1000, then req[3] drops without done -> gnt=0 next cycle; later req=0000_0110 -> grant to bit 1 (wrap path, since nothing is above 3 in req).
- done and a new req[5] in the same cycle while owner is bit 2 with req=0010_0100 -> gnt=0010_0000 next cycle.
- With ARB_TIMEOUT_EN: owner bit 1 never releases, req=0000_0110 -> after 4 BUSY cycles timeout=1 for one cycle and gnt=0000_0100. Without the macro: gnt stays 0000_0010 indefinitely and timeout=0.
- Assert rst_n=0 mid-BUSY (gnt=0100_0000) -> gnt=0 and busy=0 immediately; after release, req=1100_0000 -> grant bit 6.

Source files
------------

// File: rtl/sc_arb_pkg.sv
// Shared types and helpers for the SC-resource round-robin arbiter.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
// Contents: arb_state_e FSM encoding, lowest_onehot(), onehot_to_idx().
// Helpers work on a fixed ARB_MAXN-bit vector; callers size-cast in and out.
package sc_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_MAXN = 64;
  typedef logic [ARB_MAXN-1:0] arb_vec_t;

  // Isolate the lowest set bit (two's-complement trick); zero stays zero.
  function automatic arb_vec_t lowest_onehot(input arb_vec_t v);
    return v & (~v + arb_vec_t'(1));
  endfunction

  // Binary index of the set bit of a one-hot vector; zero maps to 0.
  function automatic int unsigned onehot_to_idx(input arb_vec_t v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ARB_MAXN; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_to_therm.sv
// One-hot to thermometer converter, used for round-robin priority masks.
// Latency: combinational, zero cycles.
// Backpressure: n/a.
// Ports: i_oh  N-bit one-hot (or zero) input
//        o_therm N-bit thermometer; DIR=1 sets the hot bit and all above,
//        DIR=0 sets the hot bit and all below. Zero input gives zero output.
module onehot_to_therm #(
  parameter int N   = 8,
  parameter int DIR = 1
) (
  input  logic [N-1:0] i_oh,
  output logic [N-1:0] o_therm
);

  generate
    if (DIR == 1) begin : g_up
      // oh-1 fills everything below the hot bit; inverting keeps hot bit and above.
      // A zero input gives all-ones minus... inverted to zero, as wanted.
      assign o_therm = ~(i_oh - N'(1));
    end else begin : g_down
      assign o_therm = (|i_oh) ? (i_oh | (i_oh - N'(1))) : '0;
    end
  endgenerate

endmodule

// File: rtl/rr_therm_arbiter.sv
// Round-robin arbiter granting one shared SC datapath resource to N requesters.
// Latency: req to gnt 1 cycle; back-to-back handover on release with no idle gap.
// Backpressure: a grant is held until done, a dropped req, or (optionally) hold timeout.
// Ports: clk, rst_n (async active-low), req[N] request levels, done (owner finished,
//        ignored when idle), gnt[N] registered one-hot grant, gnt_idx binary index of
//        gnt (held when idle), busy (= |gnt), timeout (one-cycle forced-revoke pulse).
// Optional feature macro: ARB_TIMEOUT_EN enables the MAX_HOLD hold-timeout revoke.
module rr_therm_arbiter #(
  parameter int  N        = 8,
  parameter int  MAX_HOLD = 256,
  localparam int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          busy,
  output logic          timeout
);
  import sc_arb_pkg::*;

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_last_oh;
  logic [IW-1:0] r_gnt_idx;
  logic [N-1:0]  w_therm;
  logic [N-1:0]  w_above;
  logic [N-1:0]  w_req_above;
  logic [N-1:0]  w_winner;
  logic          w_release;
  logic          w_forced;
  logic          w_load;
  logic          w_drop;

  // Priority mask: requesters strictly above the last grant.
  onehot_to_therm #(.N(N), .DIR(1)) u_mask (
    .i_oh    (r_last_oh),
    .o_therm (w_therm)
  );

  assign w_above     = w_therm & ~r_last_oh;
  assign w_req_above = req & w_above;
  // Nothing pending above the last grant means wrap to the lowest requester.
  assign w_winner    = (|w_req_above) ? N'(lowest_onehot(arb_vec_t'(w_req_above)))
                                      : N'(lowest_onehot(arb_vec_t'(req)));

  // A dropped request releases the grant just like done.
  assign w_release = (r_state == BUSY) && (done || !req[r_gnt_idx] || w_forced);

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] r_hold_cnt;
  logic          r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_load) begin
      r_hold_cnt <= '0;
    end else if ((r_state == BUSY) && !w_release) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
    end
  end

  assign w_forced = (r_state == BUSY) && (r_hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_timeout <= 1'b0;
    else        r_timeout <= w_forced;
  end

  assign timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_HOLD > 1);
  assign w_forced     = 1'b0;
  assign timeout      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = BUSY;
      BUSY:    if (w_release && !(|w_winner)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: load a new grant, or drop to idle.
  always_comb begin
    w_load = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      IDLE: w_load = |req;
      BUSY: begin
        if (w_release) begin
          if (|w_winner) w_load = 1'b1;
          else           w_drop = 1'b1;
        end
      end
      default: w_drop = 1'b1;
    endcase
  end

  // Grant datapath. last_oh resets to the top bit so the first search starts at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_last_oh <= {1'b1, {(N-1){1'b0}}};
    end else if (w_load) begin
      r_gnt     <= w_winner;
      r_gnt_idx <= IW'(onehot_to_idx(arb_vec_t'(w_winner)));
      r_last_oh <= w_winner;
    end else if (w_drop) begin
      r_gnt     <= '0;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = |r_gnt;

endmodule

// File: tb/tb_rr_therm_arbiter.sv
module tb_rr_therm_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         busy;
  logic         timeout;

  int total;
  int bad;

  rr_therm_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = requester index currently holding the resource, -1 when idle.
  // Next owner is found by a circular scan starting just after the last owner.
  int m_owner, m_last, m_idx, m_held;
  bit m_to;
  int n_owner, n_last, n_idx, n_held;
  bit n_to;

  always_comb begin
    int pk;
    bit rel;
    bit forced;
    n_owner = m_owner;
    n_last  = m_last;
    n_idx   = m_idx;
    n_held  = m_held;
    n_to    = 1'b0;
    forced  = 1'b0;
    pk      = -1;
    if (m_owner < 0) begin
      rel = 1'b1;
    end else begin
      forced = TO_EN && (m_held == MAX_HOLD);
      rel    = done || !req[m_owner] || forced;
    end
    if (rel) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (pk < 0 && req[i]) pk = i;
      end
      n_to = forced;
      if (pk >= 0) begin
        n_owner = pk;
        n_last  = pk;
        n_idx   = pk;
        n_held  = 1;
      end else begin
        n_owner = -1;
      end
    end else begin
      n_held = m_held + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= N - 1;
      m_idx   <= 0;
      m_held  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_owner <= n_owner;
      m_last  <= n_last;
      m_idx   <= n_idx;
      m_held  <= n_held;
      m_to    <= n_to;
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] one;
    logic [N-1:0] exp_gnt;
    one     = 8'd1;
    exp_gnt = (m_owner < 0) ? '0 : (one << m_owner);
    check("model_gnt",     32'(gnt),     32'(exp_gnt));
    check("model_gnt_idx", 32'(gnt_idx), 32'(m_idx));
    check("model_busy",    32'(busy),    32'(m_owner >= 0));
    check("model_timeout", 32'(timeout), 32'(m_to));
    check("onehot0_gnt",   32'($onehot0(gnt)), 32'd1);
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (2) tick();
    check("rst_gnt",     32'(gnt), 32'h00);
    check("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    tick();

    // single request, one-cycle latency, then release
    req = 8'b0000_0001;
    tick();
    check("t1_gnt", 32'(gnt), 32'h01);
    check("t1_idx", 32'(gnt_idx), 32'd0);
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t1_rel_gnt",  32'(gnt), 32'h00);
    check("t1_rel_busy", 32'(busy), 32'd0);

    // fresh reset, then rotation 0 -> 3 -> 7 -> 0 with no idle gaps
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 8'b1000_1001;
    tick();
    check("rr_g0", 32'(gnt), 32'h01);
    done = 1'b1;
    tick();
    check("rr_g3", 32'(gnt), 32'h08);
    tick();
    check("rr_g7", 32'(gnt), 32'h80);
    tick();
    check("rr_g0b", 32'(gnt), 32'h01);
    req = '0;
    tick();
    done = 1'b0;
    check("rr_idle", 32'(busy), 32'd0);

    // implicit done by dropping the request, then wrap-around selection
    req = 8'b0000_1000;
    tick();
    check("drop_g3", 32'(gnt), 32'h08);
    req = '0;
    tick();
    check("drop_gnt",  32'(gnt), 32'h00);
    check("drop_idx",  32'(gnt_idx), 32'd3);
    req = 8'b0000_0110;
    tick();
    check("wrap_g1", 32'(gnt), 32'h02);
    req = '0;
    tick();

    // done and a new request in the same cycle
    req = 8'b0000_0100;
    tick();
    check("sim_g2", 32'(gnt), 32'h04);
    req  = 8'b0010_0100;
    done = 1'b1;
    tick();
    done = 1'b0;
    check("sim_g5", 32'(gnt), 32'h20);
    req = '0;
    tick();

    // stuck owner: forced revoke only with the timeout feature
    req = 8'b0000_0010;
    tick();
    check("to_g1", 32'(gnt), 32'h02);
    req = 8'b0000_0110;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("to_hold", 32'(gnt), 32'h02);
      check("to_hold_pulse", 32'(timeout), 32'd0);
    end
    tick();
    check("to_gnt",   32'(gnt),     TO_EN ? 32'h04 : 32'h02);
    check("to_pulse", 32'(timeout), 32'(TO_EN));
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_gnt_after", 32'(gnt), TO_EN ? 32'h04 : 32'h02);
    req = '0;
    tick();

    // reset in the middle of a grant
    req = 8'b0100_0000;
    tick();
    check("mr_g6", 32'(gnt), 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_gnt",  32'(gnt), 32'h00);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_idx",  32'(gnt_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    req = 8'b1100_0000;
    tick();
    check("mr_after_g6", 32'(gnt), 32'h40);
    req = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
